// File: rtl/mem_stage_sl.sv
`default_nettype none
// ============================================================================
// mem_stage_sl : MS pipeline stage; waits for sram-like data responses,
//                buffers them under WB stall, extends loads, drops flushed ones
// Revision     : 1.0
// ============================================================================
module mem_stage_sl #(
  parameter int EXC_W      = 7,
  parameter int MAX_CANCEL = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             es_to_ms_valid,
  output logic             ms_allowin,
  input  logic [31:0]      es_pc,
  input  logic [31:0]      es_alu_result,
  input  logic             es_rf_we,
  input  logic [4:0]       es_rf_waddr,
  input  logic             es_mem_req,
  input  logic             es_res_from_mem,
  input  logic [2:0]       es_ld_op,
  input  logic [EXC_W-1:0] es_except,
  input  logic             es_cancel_req,
  input  logic             data_sram_data_ok,
  input  logic [31:0]      data_sram_rdata,
  input  logic             except_flush,
  input  logic             ws_allowin,
  output logic             ms_to_ws_valid,
  output logic [31:0]      ms_pc,
  output logic             ms_rf_we,
  output logic [4:0]       ms_rf_waddr,
  output logic [31:0]      ms_rf_wdata,
  output logic [EXC_W-1:0] ms_except,
  output logic [31:0]      ms_vaddr,
  output logic             ms_ld_wait,
  output logic             ms_mem_busy
);

  localparam int C_CNT_W = $clog2(MAX_CANCEL + 1);
  localparam int C_SUM_W = C_CNT_W + 2;

  logic             r_ms_valid;
  logic             r_buf_valid;
  logic [31:0]      r_buf;
  logic [C_CNT_W-1:0] r_cancel_cnt;
  logic [31:0]      r_pc;
  logic [31:0]      r_alu;
  logic             r_rf_we;
  logic [4:0]       r_rf_waddr;
  logic             r_mem_req;
  logic             r_res_from_mem;
  logic [2:0]       r_ld_op;
  logic [EXC_W-1:0] r_except;

  logic             w_cnt_nz;
  logic             w_owned;
  logic             w_got;
  logic             w_ready_go;
  logic             w_accept;
  logic             w_leave;
  logic             w_pending;
  logic [31:0]      w_rdata;
  logic [15:0]      w_half;
  logic [7:0]       w_byte;
  logic [31:0]      w_load_ext;
  logic [C_SUM_W-1:0] w_inc_pend;
  logic [C_SUM_W-1:0] w_inc_ex;
  logic [C_SUM_W-1:0] w_dec;
  logic [C_SUM_W-1:0] w_cnt_flush;
  logic [C_SUM_W-1:0] w_cnt_run;

  // A response is ours only once all cancelled responses ahead of it drained.
  assign w_cnt_nz   = (r_cancel_cnt != '0);
  assign w_owned    = data_sram_data_ok & ~w_cnt_nz & r_ms_valid & r_mem_req & ~r_buf_valid;
  assign w_got      = r_buf_valid | w_owned;
  assign w_ready_go = ~r_mem_req | w_got;
  assign w_pending  = r_ms_valid & r_mem_req & ~w_got;

  assign ms_to_ws_valid = r_ms_valid & w_ready_go;
  assign ms_allowin     = resetn & (~r_ms_valid | (w_ready_go & ws_allowin));
  assign w_accept       = es_to_ms_valid & ms_allowin;
  assign w_leave        = ms_to_ws_valid & ws_allowin;

  assign w_inc_pend  = {{(C_SUM_W-1){1'b0}}, w_pending};
  assign w_inc_ex    = {{(C_SUM_W-1){1'b0}}, es_cancel_req};
  assign w_dec       = {{(C_SUM_W-1){1'b0}}, data_sram_data_ok & w_cnt_nz};
  assign w_cnt_flush = {2'b00, r_cancel_cnt} + w_inc_pend + w_inc_ex - w_dec;
  assign w_cnt_run   = {2'b00, r_cancel_cnt} - w_dec;

  assign w_rdata = r_buf_valid ? r_buf : data_sram_rdata;

  always_comb begin
    w_half     = r_alu[1] ? w_rdata[31:16] : w_rdata[15:0];
    w_byte     = w_rdata[7:0];
    w_load_ext = '0;
    case (r_alu[1:0])
      2'd1:    w_byte = w_rdata[15:8];
      2'd2:    w_byte = w_rdata[23:16];
      2'd3:    w_byte = w_rdata[31:24];
      default: w_byte = w_rdata[7:0];
    endcase
    case (r_ld_op)
      3'd0:    w_load_ext = w_rdata;
      3'd1:    w_load_ext = {{16{w_half[15]}}, w_half};
      3'd2:    w_load_ext = {16'h0000, w_half};
      3'd3:    w_load_ext = {{24{w_byte[7]}}, w_byte};
      3'd4:    w_load_ext = {24'h000000, w_byte};
      default: w_load_ext = '0;
    endcase
  end

  assign ms_pc       = r_pc;
  assign ms_vaddr    = r_alu;
  assign ms_rf_we    = r_ms_valid & r_rf_we;
  assign ms_rf_waddr = r_rf_waddr;
  assign ms_rf_wdata = r_res_from_mem ? w_load_ext : r_alu;
  assign ms_except   = r_ms_valid ? r_except : '0;
  assign ms_ld_wait  = r_ms_valid & r_res_from_mem & r_mem_req & ~w_got;
  assign ms_mem_busy = w_pending | w_cnt_nz;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_ms_valid     <= 1'b0;
      r_buf_valid    <= 1'b0;
      r_buf          <= '0;
      r_cancel_cnt   <= '0;
      r_pc           <= '0;
      r_alu          <= '0;
      r_rf_we        <= 1'b0;
      r_rf_waddr     <= '0;
      r_mem_req      <= 1'b0;
      r_res_from_mem <= 1'b0;
      r_ld_op        <= '0;
      r_except       <= '0;
    end else if (except_flush) begin
      r_ms_valid   <= 1'b0;
      r_buf_valid  <= 1'b0;
      r_cancel_cnt <= w_cnt_flush[C_CNT_W-1:0];
    end else begin
      r_cancel_cnt <= w_cnt_run[C_CNT_W-1:0];
      if (w_accept) begin
        r_ms_valid     <= 1'b1;
        r_buf_valid    <= 1'b0;
        r_pc           <= es_pc;
        r_alu          <= es_alu_result;
        r_rf_we        <= es_rf_we;
        r_rf_waddr     <= es_rf_waddr;
        r_mem_req      <= es_mem_req;
        r_res_from_mem <= es_res_from_mem;
        r_ld_op        <= es_ld_op;
        r_except       <= es_except;
      end else if (w_leave) begin
        r_ms_valid  <= 1'b0;
        r_buf_valid <= 1'b0;
      end else if (w_owned && !ws_allowin) begin
        r_buf_valid <= 1'b1;
        r_buf       <= data_sram_rdata;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_sl.sv
`default_nettype none
// ============================================================================
// tb_mem_stage_sl : directed + random bench for mem_stage_sl against a
//                   behavioural slot / cancelled-response model
// Revision        : 1.0
// ============================================================================
module tb_mem_stage_sl;
  localparam int EXC_W      = 7;
  localparam int MAX_CANCEL = 3;

  logic             clk = 1'b0;
  logic             resetn;
  logic             es_to_ms_valid;
  logic             ms_allowin;
  logic [31:0]      es_pc;
  logic [31:0]      es_alu_result;
  logic             es_rf_we;
  logic [4:0]       es_rf_waddr;
  logic             es_mem_req;
  logic             es_res_from_mem;
  logic [2:0]       es_ld_op;
  logic [EXC_W-1:0] es_except;
  logic             es_cancel_req;
  logic             data_sram_data_ok;
  logic [31:0]      data_sram_rdata;
  logic             except_flush;
  logic             ws_allowin;
  logic             ms_to_ws_valid;
  logic [31:0]      ms_pc;
  logic             ms_rf_we;
  logic [4:0]       ms_rf_waddr;
  logic [31:0]      ms_rf_wdata;
  logic [EXC_W-1:0] ms_except;
  logic [31:0]      ms_vaddr;
  logic             ms_ld_wait;
  logic             ms_mem_busy;

  int n_pass  = 0;
  int n_total = 0;

  // Model: one instruction slot plus a count of responses still owed to
  // requests that were flushed away.
  bit               m_valid;
  logic [31:0]      m_pc, m_alu, m_data;
  bit               m_rf_we, m_mem_req, m_load, m_have;
  logic [4:0]       m_waddr;
  logic [2:0]       m_ld_op;
  logic [EXC_W-1:0] m_except;
  int               m_dead;
  bit               s_owned, s_got, s_allow, s_tows;

  always #5 clk = ~clk;

  mem_stage_sl #(.EXC_W(EXC_W), .MAX_CANCEL(MAX_CANCEL)) dut (
    .clk(clk), .resetn(resetn),
    .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
    .es_pc(es_pc), .es_alu_result(es_alu_result), .es_rf_we(es_rf_we),
    .es_rf_waddr(es_rf_waddr), .es_mem_req(es_mem_req),
    .es_res_from_mem(es_res_from_mem), .es_ld_op(es_ld_op),
    .es_except(es_except), .es_cancel_req(es_cancel_req),
    .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .except_flush(except_flush), .ws_allowin(ws_allowin),
    .ms_to_ws_valid(ms_to_ws_valid), .ms_pc(ms_pc), .ms_rf_we(ms_rf_we),
    .ms_rf_waddr(ms_rf_waddr), .ms_rf_wdata(ms_rf_wdata),
    .ms_except(ms_except), .ms_vaddr(ms_vaddr), .ms_ld_wait(ms_ld_wait),
    .ms_mem_busy(ms_mem_busy)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] ld_ext(logic [2:0] op, logic [1:0] off, logic [31:0] d);
    logic [15:0] h;
    logic [7:0]  b;
    h = 16'(d >> (16 * int'(off[1])));
    b = 8'(d >> (8 * int'(off)));
    case (op)
      3'd0:    return d;
      3'd1:    return 32'($signed(h));
      3'd2:    return 32'(h);
      3'd3:    return 32'($signed(b));
      3'd4:    return 32'(b);
      default: return 32'h0;
    endcase
  endfunction

  // Compare every output against the model for the current inputs.
  task automatic settle();
    bit legal, ready, ldw, busy;
    logic [31:0] d;
    #2;
    legal   = (m_dead > 0) || (m_valid && m_mem_req && !m_have);
    s_owned = data_sram_data_ok && m_dead == 0 && m_valid && m_mem_req && !m_have;
    s_got   = m_have || s_owned;
    ready   = !m_mem_req || s_got;
    s_tows  = m_valid && ready;
    s_allow = resetn && (!m_valid || (ready && ws_allowin));
    ldw     = m_valid && m_load && m_mem_req && !s_got;
    busy    = (m_dead > 0) || (m_valid && m_mem_req && !s_got);
    if (data_sram_data_ok) chk("proto_data_ok", 32'(legal), 32'd1);
    chk("to_ws_valid", 32'(ms_to_ws_valid), 32'(s_tows));
    chk("allowin", 32'(ms_allowin), 32'(s_allow));
    chk("rf_we", 32'(ms_rf_we), 32'(m_valid && m_rf_we));
    chk("except", 32'(ms_except), m_valid ? 32'(m_except) : 32'd0);
    chk("ld_wait", 32'(ms_ld_wait), 32'(ldw));
    chk("mem_busy", 32'(ms_mem_busy), 32'(busy));
    if (m_valid) begin
      d = m_have ? m_data : data_sram_rdata;
      chk("pc", ms_pc, m_pc);
      chk("vaddr", ms_vaddr, m_alu);
      chk("waddr", 32'(ms_rf_waddr), 32'(m_waddr));
      chk("wdata", ms_rf_wdata, m_load ? ld_ext(m_ld_op, m_alu[1:0], d) : m_alu);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    if (!resetn) begin
      m_valid = 0; m_have = 0; m_dead = 0;
      m_pc = '0; m_alu = '0; m_data = '0; m_rf_we = 0; m_mem_req = 0;
      m_load = 0; m_waddr = '0; m_ld_op = '0; m_except = '0;
    end else if (except_flush) begin
      m_dead = m_dead + int'(m_valid && m_mem_req && !s_got) + int'(es_cancel_req)
               - int'(data_sram_data_ok && m_dead > 0);
      m_valid = 0;
      m_have  = 0;
      chk("cancel_bound", 32'(m_dead <= MAX_CANCEL), 32'd1);
    end else begin
      if (data_sram_data_ok && m_dead > 0) m_dead--;
      if (s_owned && !ws_allowin) begin
        m_have = 1;
        m_data = data_sram_rdata;
      end
      if (es_to_ms_valid && s_allow) begin
        m_valid = 1; m_have = 0;
        m_pc = es_pc; m_alu = es_alu_result; m_rf_we = es_rf_we;
        m_waddr = es_rf_waddr; m_mem_req = es_mem_req; m_load = es_res_from_mem;
        m_ld_op = es_ld_op; m_except = es_except;
      end else if (s_tows && ws_allowin) begin
        m_valid = 0;
        m_have  = 0;
      end
    end
    #1;
  endtask

  task automatic ex_issue(logic [31:0] pc, logic [31:0] alu, logic we, logic [4:0] wa,
                          logic mreq, logic ld, logic [2:0] op, logic [EXC_W-1:0] exc);
    es_to_ms_valid = 1; es_pc = pc; es_alu_result = alu; es_rf_we = we;
    es_rf_waddr = wa; es_mem_req = mreq; es_res_from_mem = ld; es_ld_op = op;
    es_except = exc;
  endtask

  task automatic ex_idle();
    es_to_ms_valid = 0; es_mem_req = 0; es_res_from_mem = 0; es_except = '0;
  endtask

  initial begin
    resetn = 0; ex_idle(); es_pc = '0; es_alu_result = '0; es_rf_we = 0;
    es_rf_waddr = '0; es_ld_op = '0; es_cancel_req = 0; data_sram_data_ok = 0;
    data_sram_rdata = '0; except_flush = 0; ws_allowin = 1;
    advance(); advance();

    // reset state
    settle();
    chk("rst_allowin", 32'(ms_allowin), 32'd0);
    chk("rst_pc", ms_pc, 32'd0);
    chk("rst_wdata", ms_rf_wdata, 32'd0);
    resetn = 1;
    advance();

    // ld.b then ld.bu, second enters while first leaves on its data_ok
    ex_issue(32'h1c00_0000, 32'h0000_1003, 1, 5'd4, 1, 1, 3'd3, '0);
    settle(); advance();
    ex_issue(32'h1c00_0004, 32'h0000_1003, 1, 5'd5, 1, 1, 3'd4, '0);
    data_sram_data_ok = 1; data_sram_rdata = 32'h80FF_1234;
    settle();
    chk("ldb_wdata", ms_rf_wdata, 32'hFFFF_FF80);
    chk("ldb_to_ws", 32'(ms_to_ws_valid), 32'd1);
    chk("ldb_allowin", 32'(ms_allowin), 32'd1);
    advance();
    ex_idle();
    settle();
    chk("ldbu_wdata", ms_rf_wdata, 32'h0000_0080);
    chk("ldbu_to_ws", 32'(ms_to_ws_valid), 32'd1);
    advance();
    data_sram_data_ok = 0;

    // ld.h response buffered across a 3-cycle WB stall
    ex_issue(32'h1c00_0010, 32'h0000_2002, 1, 5'd6, 1, 1, 3'd1, '0);
    settle(); advance();
    ex_idle(); ws_allowin = 0;
    data_sram_data_ok = 1; data_sram_rdata = 32'h8001_7FFF;
    settle();
    chk("ldh_wdata_ok", ms_rf_wdata, 32'hFFFF_8001);
    advance();
    data_sram_data_ok = 0; data_sram_rdata = 32'h1234_5678;
    for (int k = 0; k < 2; k++) begin
      settle();
      chk("ldh_buf_to_ws", 32'(ms_to_ws_valid), 32'd1);
      chk("ldh_buf_wdata", ms_rf_wdata, 32'hFFFF_8001);
      advance();
    end
    ws_allowin = 1;
    settle(); advance();
    settle();
    chk("ldh_left", 32'(ms_to_ws_valid), 32'd0);
    advance();

    // flush with a pending ld.w plus an EX request: two responses dropped
    ex_issue(32'h1c00_0020, 32'h0000_3000, 1, 5'd7, 1, 1, 3'd0, '0);
    settle(); advance();
    ex_idle(); except_flush = 1; es_cancel_req = 1;
    settle(); advance();
    except_flush = 0; es_cancel_req = 0;
    data_sram_data_ok = 1; data_sram_rdata = 32'h1111_1111;
    settle(); advance();
    data_sram_rdata = 32'h2222_2222;
    settle();
    chk("cancel_busy_last", 32'(ms_mem_busy), 32'd1);
    advance();
    data_sram_data_ok = 0;
    ex_issue(32'h1c00_0024, 32'h0000_3004, 1, 5'd8, 1, 1, 3'd0, '0);
    settle();
    chk("cancel_drained", 32'(ms_mem_busy), 32'd0);
    advance();
    ex_idle(); data_sram_data_ok = 1; data_sram_rdata = 32'hDEAD_BEEF;
    settle();
    chk("third_resp", ms_rf_wdata, 32'hDEAD_BEEF);
    chk("third_to_ws", 32'(ms_to_ws_valid), 32'd1);
    advance();
    data_sram_data_ok = 0;

    // flush coinciding with a dropped response and a new EX cancel
    ex_issue(32'h1c00_0030, 32'h0000_4000, 1, 5'd9, 1, 1, 3'd0, '0);
    settle(); advance();
    ex_idle(); except_flush = 1;
    settle(); advance();
    es_cancel_req = 1; data_sram_data_ok = 1;
    settle(); advance();
    except_flush = 0; es_cancel_req = 0;
    settle();
    chk("cnt_kept_busy", 32'(ms_mem_busy), 32'd1);
    advance();
    data_sram_data_ok = 0;
    settle();
    chk("cnt_kept_zero", 32'(ms_mem_busy), 32'd0);
    advance();

    // exception without memory request passes straight through
    ex_issue(32'h1c00_0040, 32'h5555_1234, 0, 5'd0, 0, 0, 3'd0, 7'h04);
    settle(); advance();
    ex_idle();
    settle();
    chk("exc_flags", 32'(ms_except), 32'h04);
    chk("exc_to_ws", 32'(ms_to_ws_valid), 32'd1);
    chk("exc_vaddr", ms_vaddr, 32'h5555_1234);
    advance();

    // ALU stream, reset asserted mid-stream
    ws_allowin = 1;
    for (int i = 0; i < 8; i++) begin
      if (i == 5) begin
        resetn = 0;
        settle(); advance();
        ex_idle();
        settle();
        chk("mid_rst_to_ws", 32'(ms_to_ws_valid), 32'd0);
        chk("mid_rst_allowin", 32'(ms_allowin), 32'd0);
        chk("mid_rst_rf_we", 32'(ms_rf_we), 32'd0);
        chk("mid_rst_pc", ms_pc, 32'd0);
        chk("mid_rst_wdata", ms_rf_wdata, 32'd0);
        chk("mid_rst_waddr", 32'(ms_rf_waddr), 32'd0);
        chk("mid_rst_vaddr", ms_vaddr, 32'd0);
        resetn = 1;
        advance();
      end
      ex_issue(32'h0000_0100 + 32'(4 * i), 32'(i) * 32'h1111_1111, 1'(i), 5'(i + 1),
               0, 0, 3'd0, '0);
      settle();
      if (i != 0 && i != 5) chk("alu_stream_to_ws", 32'(ms_to_ws_valid), 32'd1);
      advance();
    end
    ex_idle();
    settle(); advance();

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      bit pend;
      pend = m_valid && m_mem_req && !m_have;
      ws_allowin        = ($urandom_range(0, 3) != 0);
      data_sram_data_ok = (m_dead > 0 || pend) && ($urandom_range(0, 1) == 1);
      data_sram_rdata   = $urandom;
      es_cancel_req     = ($urandom_range(0, 1) == 1);
      except_flush      = ($urandom_range(0, 11) == 0) &&
                          (m_dead + int'(pend) + int'(es_cancel_req) <= MAX_CANCEL);
      if (!except_flush) es_cancel_req = 0;
      es_to_ms_valid  = ($urandom_range(0, 2) != 0);
      es_pc           = $urandom;
      es_alu_result   = $urandom;
      es_rf_we        = 1'($urandom_range(0, 1));
      es_rf_waddr     = 5'($urandom);
      es_except       = ($urandom_range(0, 7) == 0) ? 7'($urandom) : '0;
      es_mem_req      = (es_except == '0) && ($urandom_range(0, 1) == 1);
      es_res_from_mem = es_mem_req && ($urandom_range(0, 1) == 1);
      es_ld_op        = 3'($urandom_range(0, 7));
      settle(); advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_stage_sl.md
# mem_stage_sl

Memory-access pipeline stage for the 5-stage LoongArch core, between EX and WB, for a variable-latency sram-like data interface (data_ok/rdata). It holds one instruction and waits for its load or store response. It buffers a response that arrives while WB is stalled, and sign- or zero-extends sub-word loads. It also discards responses that belong to requests cancelled by an exception flush.

## Interface
- EXC_W, 7, width of the exception-flag vector carried with each instruction
- MAX_CANCEL, 3, maximum number of cancelled in-flight responses tracked; counter width is clog2(MAX_CANCEL+1)
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- es_to_ms_valid  in  1  EX holds a valid instruction for MS
- ms_allowin  out  1  MS accepts an instruction this cycle
- es_pc  in  32  PC of the EX instruction
- es_alu_result  in  32  ALU result, which is the memory vaddr for loads/stores
- es_rf_we  in  1  register write enable
- es_rf_waddr  in  5  destination register
- es_mem_req  in  1  EX issued a data request that was accepted (addr_ok) for this instruction
- es_res_from_mem  in  1  instruction is a load
- es_ld_op  in  3  load type: 0 ld.w, 1 ld.h, 2 ld.hu, 3 ld.b, 4 ld.bu
- es_except  in  EXC_W  exception flags from earlier stages
- es_cancel_req  in  1  during the flush cycle, EX has an addr_ok-accepted request that will not enter MS
- data_sram_data_ok  in  1  response strobe; responses return in request order
- data_sram_rdata  in  32  response data
- except_flush  in  1  exception/ertn flush from WB
- ws_allowin  in  1  WB accepts
- ms_to_ws_valid  out  1  MS hands its instruction to WB
- ms_pc  out  32  latched PC
- ms_rf_we, ms_rf_waddr, ms_rf_wdata  out  1/5/32  writeback bundle; ms_rf_we is already gated by ms_valid
- ms_except  out  EXC_W  latched exception flags, gated by ms_valid
- ms_vaddr  out  32  latched es_alu_result, used for BADV
- ms_ld_wait  out  1  ms_valid & load & response not yet available; consumers stall forwarding on this
- ms_mem_busy  out  1  an uncancelled request is outstanding, or cancel_cnt != 0

## Operation
- Accept: on es_to_ms_valid & ms_allowin, latch pc, alu_result, rf_we, waddr, mem_req, res_from_mem, ld_op, except; set ms_valid=1 and clear buf_valid.
- Otherwise, when ms_to_ws_valid & ws_allowin, clear ms_valid.
- EX never asserts es_mem_req together with a nonzero es_except.
- Response ownership:
  - If cancel_cnt != 0, data_ok decrements cancel_cnt and is otherwise ignored.
  - Else, if ms_valid & mem_req & ~buf_valid, the response belongs to MS.
  - Otherwise data_ok is a protocol error; the bench asserts this never happens.
- got = buf_valid | (owned data_ok this cycle).
- ms_ready_go = ~mem_req | got.
- ms_allowin = ~ms_valid | (ms_ready_go & ws_allowin).
- Buffer: an owned data_ok with ~ws_allowin stores rdata in buf and sets buf_valid. Rdata used = buf_valid ? buf : data_sram_rdata.
- Load extension, with off = vaddr[1:0]:
  - w: the full word.
  - h/hu: select the half by off[1] and extend its bit 15.
  - b/bu: select the byte by off and extend its bit 7.
  - Sign extension applies to ld.h and ld.b only; ld_op values 5–7 give 0.
- ms_rf_wdata = res_from_mem ? extended load : alu_result.
- Flush (except_flush=1):
  - Clear ms_valid and buf_valid; nothing is accepted that cycle.
  - cancel_cnt_next = cancel_cnt + (ms_valid & mem_req & ~got) + es_cancel_req − (data_ok & cancel_cnt != 0).
  - Any owned data_ok arriving in the flush cycle counts as got.
- Reset: ms_valid, buf_valid, cancel_cnt, all latched fields and every output are 0.

## Timing
- Non-memory instruction: accepted at edge N, ms_to_ws_valid=1 in cycle N+1.
- Memory instruction: ms_to_ws_valid is asserted in the same cycle as its data_ok. This is a combinational path from data_ok, with no added latency.
- A response buffered while WB is stalled is presented from the next cycle until WB accepts it.
- Back-to-back throughput is one instruction per cycle when data_ok returns in the cycle after entry.
- Simultaneous leave and enter in one cycle is allowed: MS is reloaded with the new instruction.
- The cancel counter must reach MAX_CANCEL+1 only on a protocol violation; the bench asserts it never overflows.
- Reset dominates flush, and flush dominates accept.

## Test plan
- ld.b at vaddr 0x1003, data_ok one cycle after entry, rdata 0x80FF_1234 → ms_rf_wdata 0xFFFF_FF80, ms_to_ws_valid in the data_ok cycle. Repeat with ld.bu → 0x0000_0080.
- ld.h at 0x2002 with rdata 0x8001_7FFF, data_ok while ws_allowin=0 for 3 cycles → buf holds the data, ms_to_ws_valid stays 1, wdata 0xFFFF_8001, then exit when ws_allowin rises.
- ld.w outstanding and except_flush with es_cancel_req=1 → cancel_cnt=2. Then the next two data_ok are dropped and a new ld.w entering afterwards receives the third data_ok, 0xDEAD_BEEF.
- Flush in the same cycle as a cancelled data_ok with es_cancel_req=1 → cancel_cnt unchanged at 1.
- ALU instruction stream of 8 ops with ws_allowin=1 → one per cycle and ms_rf_we gated correctly. Assert resetn=0 mid-stream → all outputs 0 on the next cycle.
- es_except=0x04 with no mem_req → ms_except=0x04, ready_go immediately, ms_vaddr equals es_alu_result.
